// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a byte FIFO fed by core stores, a programmable
// baud divisor, and a four-state serialiser driving the idle-high tx line.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] aluresult,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      act_div_q, act_div_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic       wr_en, push, push_ok, pop, full, empty, busy, bit_end;
  logic [1:0] reg_addr;
  logic       unused_bits;

  assign sel         = (aluresult[31:4] == BASE_ADDR[31:4]);
  assign reg_addr    = aluresult[3:2];
  assign wr_en       = memwrite & sel;
  assign full        = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (cnt_q == '0);
  assign busy        = (state_q != S_IDLE);
  assign push        = wr_en && (reg_addr == 2'd0);
  // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push.
  assign push_ok     = push && !full;
  assign pop         = (state_q == S_IDLE) && !empty;
  assign bit_end     = (baud_q == act_div_q - 16'd1);
  assign unused_bits = ^{aluresult[1:0], writedata[31:16]};

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_addr)
        2'd1:    rdata = {28'd0, ovf_q, busy, empty, full};
        2'd2:    rdata = {16'd0, div_q};
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    div_d     = div_q;
    act_div_d = act_div_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;

    if (push_ok) wptr_d = wptr_q + PTR_W'(1);
    if (push && full) begin
      ovf_d = 1'b1;
    end else if (wr_en && (reg_addr == 2'd1) && writedata[3]) begin
      ovf_d = 1'b0;
    end
    if (wr_en && (reg_addr == 2'd2)) begin
      div_d = (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d   = fifo_q[rptr_q];
          rptr_d    = rptr_q + PTR_W'(1);
          act_div_d = div_q;
          baud_d    = '0;
          bit_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  // Payload storage carries no reset; the pointers and count alone define FIFO contents.
  always_ff @(posedge clk) begin
    act_div_q <= act_div_d;
    shift_q   <= shift_d;
    if (push_ok) fifo_q[wptr_q] <= writedata[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores queue expected bytes, a line monitor
// decodes 8N1 frames from tx and checks byte value, frame shape and spacing.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          DIV_RST = 868;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] aluresult = '0;
  logic [31:0] writedata = '0;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_div = DIV_RST;
  int rst_epoch = 0;
  bit mon_busy = 1'b0;
  logic [7:0] sb [$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .DIV_RESET(16'd868)) dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .aluresult(aluresult),
    .writedata(writedata), .sel(sel), .rdata(rdata), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    aluresult = addr;
    writedata = data;
    memwrite  = 1'b1;
    @(posedge clk);
    #1 memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    aluresult = addr;
    memwrite  = 1'b0;
    #1 check(name, rdata, exp);
  endtask

  task automatic set_div(input int d);
    wr(BASE + 32'h8, 32'(d));
    mdl_div = (d == 0) ? 1 : d;
  endtask

  task automatic send(input logic [7:0] b);
    wr(BASE, {24'd0, b});
    sb.push_back(b);
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !mon_busy) break;
      @(negedge clk);
    end
    n_tests++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes still pending after %0d cycles, required 0", sb.size(), budget);
    end
  endtask

  // Line monitor: decodes each frame using the divisor in force when its start bit appears.
  initial begin : monitor
    bit expect_start;
    int exp_ep, d, ep;
    bit have, ok, aborted;
    logic [7:0] exp_b, got;
    logic first, idle, b2b;
    expect_start = 1'b0;
    exp_ep = 0;
    wait (rst == 1'b0);
    forever begin
      @(negedge clk);
      if (expect_start && rst_epoch == exp_ep) check("frame_gap", 32'(tx), 32'd0);
      expect_start = 1'b0;
      if (tx === 1'b0 && !rst) begin
        mon_busy = 1'b1;
        d = mdl_div;
        ep = rst_epoch;
        have = (sb.size() > 0);
        exp_b = have ? sb.pop_front() : 8'h00;
        ok = 1'b1;
        got = '0;
        aborted = 1'b0;
        first = 1'b0;
        idle = 1'b0;
        b2b = 1'b0;
        for (int i = 0; i < 10 * d; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_epoch != ep) begin
            aborted = 1'b1;
            break;
          end
          if (i % d == 0) first = tx;
          else if (tx !== first) ok = 1'b0;
          if (i / d == 9 && tx !== 1'b1) ok = 1'b0;
          if (i / d >= 1 && i / d <= 8 && i % d == d / 2) got[i / d - 1] = tx;
        end
        if (!aborted) begin
          @(negedge clk);
          if (rst_epoch != ep) aborted = 1'b1;
          else begin
            idle = tx;
            b2b = (sb.size() > 0);
          end
        end
        if (!aborted) begin
          if (!have) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got byte 0x%0h on the line, required no frame", got);
          end else begin
            check("frame_byte", 32'(got), 32'(exp_b));
            check("frame_shape", 32'(ok), 32'd1);
            check("frame_idle", 32'(idle), 32'd1);
          end
          expect_start = b2b;
          exp_ep = ep;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_tx", 32'(tx), 32'd1);
    rd(BASE + 32'h4, 32'h2, "reset_status");
    rd(BASE + 32'h8, 32'(DIV_RST), "reset_baud");
    rd(BASE + 32'h0, 32'h0, "txdata_read");

    // Single frame with status tracking across the pop
    set_div(4);
    send(8'hA5);
    rd(BASE + 32'h4, 32'h0, "status_after_push");
    rd(BASE + 32'h4, 32'h6, "status_after_pop");
    repeat (10) @(negedge clk);
    rd(BASE + 32'h4, 32'h6, "status_midframe");
    drain(200);
    rd(BASE + 32'h4, 32'h2, "status_done");

    // Overflow: five back-to-back fit, the sixth is dropped
    for (int k = 1; k <= 5; k++) send(8'(k));
    rd(BASE + 32'h4, 32'h5, "status_full");
    wr(BASE, 32'h06);
    rd(BASE + 32'h4, 32'hD, "status_overflow");
    wr(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, 32'h5, "status_ovf_clear");
    drain(600);

    // Divisor change during DATA applies only to the following frame
    set_div(4);
    send(8'h00);
    send(8'hC3);
    repeat (12) @(negedge clk);
    set_div(2);
    drain(300);

    // Decode
    @(negedge clk);
    aluresult = BASE + 32'h10;
    writedata = 32'h55;
    memwrite  = 1'b1;
    #1 check("sel_outside", 32'(sel), 32'd0);
    @(posedge clk);
    #1 memwrite = 1'b0;
    rd(BASE + 32'h10, 32'h0, "rdata_outside");
    repeat (10) @(negedge clk);
    drain(100);
    set_div(0);
    rd(BASE + 32'h8, 32'h1, "baud_zero");
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    rd(BASE + 32'hC, 32'h0, "reserved_read");
    rd(BASE + 32'hB, 32'h1, "baud_after_reserved");
    rd(BASE + 32'h6, 32'h2, "status_low_bits_ignored");

    // Randomised bursts at random divisors
    for (int b = 0; b < 6; b++) begin
      int d, n;
      d = $urandom_range(1, 6);
      n = $urandom_range(1, 5);
      set_div(d);
      for (int k = 0; k < n; k++) begin
        send(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(1000);
    end

    // Reset mid-frame with two bytes queued
    set_div(4);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    repeat (10) @(negedge clk);
    @(negedge clk);
    rst_epoch++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    mdl_div = DIV_RST;
    check("midreset_tx", 32'(tx), 32'd1);
    rd(BASE + 32'h4, 32'h2, "midreset_status");
    rd(BASE + 32'h8, 32'(DIV_RST), "midreset_baud");
    repeat (100) @(negedge clk);
    drain(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
